// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 1023;

  // Requester slots as wired in FullSystemTop.
  localparam int PORT_IFETCH = 0;
  localparam int PORT_DATA   = 1;
  localparam int PORT_LOADER = 2;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first valid port after last_grant, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//   valid      - per-port request vector
//   last_grant - index of the most recently served port
//   grant      - chosen index (0 when nothing is valid)
//   any_valid  - at least one port is requesting
module rr_picker #(
  parameter int NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0]         valid,
  input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
  output logic [$clog2(NUM_PORTS)-1:0] grant,
  output logic                         any_valid
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = |valid;
    // Scan from the farthest candidate back to the nearest so that the
    // nearest valid port after last_grant is the one left in grant.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_PORTS);
      if (valid[cand]) begin
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller request port among NUM_PORTS requesters, round-robin.
// Latency: accept -> mem_req_valid 1 cycle; mem_resp_valid -> resp_valid 1 cycle.
// Backpressure: one transaction in flight; req_ready only in IDLE, mem_req held until mem_req_ready.
//
// Ports:
//   clock, reset          - system clock, async active-high reset
//   req_*                 - flattened per-port request channel (port i at [i*W +: W])
//   resp_valid/rdata/err  - registered response strobe to the granted port
//   mem_req_*             - latched request to the SDRAM controller
//   mem_resp_*            - completion from the controller (reads and writes)
//   busy                  - a transaction is in progress
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]       req_wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0]   req_wmask,
  input  logic [NUM_PORTS-1:0]              req_we,
  output logic [NUM_PORTS-1:0]              resp_valid,
  output logic [DATA_W-1:0]                 resp_rdata,
  output logic                              resp_err,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [ADDR_W-1:0]                 mem_req_addr,
  output logic [DATA_W-1:0]                 mem_req_wdata,
  output logic [DATA_W/8-1:0]               mem_req_wmask,
  output logic                              mem_req_we,
  input  logic                              mem_resp_valid,
  input  logic [DATA_W-1:0]                 mem_resp_rdata,
  output logic                              busy
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MASK_W = DATA_W / 8;

  arb_state_e       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] pick;
  logic             any_valid;
  logic [CNT_W-1:0] wd_cnt;
  logic             accept;
  logic             timeout_hit;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any_valid  (any_valid)
  );

  assign accept        = (state == IDLE) && any_valid;
  assign timeout_hit   = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_req_valid = (state == ISSUE);
  assign busy          = (state != IDLE);

  // Grant is combinational from req_valid; it is masked during reset so
  // every output reads zero while reset is held.
  always_comb begin
    req_ready = '0;
    if (accept && !reset) begin
      req_ready[pick] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(NUM_PORTS - 1);
      grant_q       <= '0;
      wd_cnt        <= '0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      mem_req_we    <= 1'b0;
      resp_valid    <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_q       <= pick;
            mem_req_addr  <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
            mem_req_wdata <= req_wdata[int'(pick)*DATA_W +: DATA_W];
            mem_req_wmask <= req_wmask[int'(pick)*MASK_W +: MASK_W];
            mem_req_we    <= req_we[pick];
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            wd_cnt <= '0;
            state  <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          // A real completion wins over the watchdog on the same cycle.
          if (mem_resp_valid || timeout_hit) begin
            resp_valid[grant_q] <= 1'b1;
            resp_rdata          <= mem_resp_valid ? mem_resp_rdata : '0;
            resp_err            <= !mem_resp_valid;
            last_grant          <= grant_q;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: bench controller varies mem_req_ready and response delays.
module tb_sdram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 16;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*MW-1:0] req_wmask;
  logic [N-1:0]    req_we;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic [MW-1:0]   mem_req_wmask;
  logic            mem_req_we;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_rdata;
  logic            busy;

  sdram_port_arbiter #(
    .NUM_PORTS      (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .req_we         (req_we),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_we     (mem_req_we),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: phase 0 = free, 1 = request offered, 2 = awaiting completion.
  int            ph = 0;
  int            last = N - 1;
  int            g = 0;
  int            rdy_dly = 0;
  int            resp_at = 0;
  int            wcyc = 0;
  int            n_done = 0;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [MW-1:0] c_wmask;
  logic          c_we;
  bit            exp_rv = 1'b0;
  int            exp_port = 0;
  logic [DW-1:0] exp_rdata;
  bit            exp_err = 1'b0;
  bit [N-1:0]    done_p = '0;
  int            grants_q[$];

  // Stimulus knobs.
  int            req_pct = 0;
  bit            drop_en = 1'b0;
  int            stray_pct = 0;
  int            fix_rdy = -1;
  int            fix_resp = -1;
  bit            fix_rdata_en = 1'b0;
  logic [DW-1:0] fix_rdata = '0;
  bit            dir_en = 1'b0;
  int            dir_port = 0;
  logic [AW-1:0] dir_addr;
  logic [DW-1:0] dir_wdata;
  logic [MW-1:0] dir_wmask;
  logic          dir_we;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next port after l in cyclic order that is requesting, or -1.
  function automatic int rr_pick(input logic [N-1:0] v, input int l);
    for (int i = 1; i <= N; i++) begin
      if (v[(l + i) % N]) return (l + i) % N;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, req_ready, 0);
    check_val({tag, "_resp_valid"}, resp_valid, 0);
    check_val({tag, "_resp_rdata"}, resp_rdata, 0);
    check_val({tag, "_resp_err"}, resp_err, 0);
    check_val({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check_val({tag, "_mem_req_fields"}, {mem_req_addr, mem_req_we, mem_req_wmask}, 0);
    check_val({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  task automatic step();
    logic [N-1:0] v;
    int pk;
    @(negedge clock);
    // Requesters: drop after a grant, scramble idle fields, maybe start a request.
    for (int p = 0; p < N; p++) begin
      if (done_p[p]) begin
        req_valid[p] = 1'b0;
        done_p[p] = 1'b0;
      end
      if (!req_valid[p]) begin
        req_addr[p*AW +: AW]  = AW'($urandom);
        req_wdata[p*DW +: DW] = $urandom;
        req_wmask[p*MW +: MW] = MW'($urandom);
        req_we[p]             = 1'($urandom);
        if (int'($urandom_range(99, 0)) < req_pct) req_valid[p] = 1'b1;
      end else if (drop_en && $urandom_range(31, 0) == 0) begin
        req_valid[p] = 1'b0;
      end
    end
    if (dir_en) begin
      req_addr[dir_port*AW +: AW]  = dir_addr;
      req_wdata[dir_port*DW +: DW] = dir_wdata;
      req_wmask[dir_port*MW +: MW] = dir_wmask;
      req_we[dir_port]             = dir_we;
      req_valid[dir_port]          = 1'b1;
      dir_en = 1'b0;
    end
    // Controller.
    mem_resp_valid = 1'b0;
    mem_resp_rdata = $urandom;
    if (ph == 1) mem_req_ready = (rdy_dly == 0);
    else         mem_req_ready = ($urandom_range(3, 0) == 0);
    if (ph == 2) begin
      if (wcyc + 1 == resp_at) begin
        mem_resp_valid = 1'b1;
        if (fix_rdata_en) mem_resp_rdata = fix_rdata;
      end
    end else if (int'($urandom_range(99, 0)) < stray_pct) begin
      mem_resp_valid = 1'b1;
    end
    #1;
    // Compare against the model.
    v = '0;
    pk = (ph == 0) ? rr_pick(req_valid, last) : -1;
    if (pk >= 0) v[pk] = 1'b1;
    check_val("req_ready", req_ready, v);
    check_val("busy", busy, (ph != 0));
    check_val("mem_req_valid", mem_req_valid, (ph == 1));
    if (ph == 1) begin
      check_val("mem_req_addr", mem_req_addr, c_addr);
      check_val("mem_req_wdata", mem_req_wdata, c_wdata);
      check_val("mem_req_wmask_we", {mem_req_wmask, mem_req_we}, {c_wmask, c_we});
    end
    check_val("resp_valid", resp_valid, exp_rv ? (64'd1 << exp_port) : 64'd0);
    if (exp_rv) begin
      check_val("resp_rdata", resp_rdata, exp_rdata);
      check_val("resp_err", resp_err, exp_err);
    end
    // Advance the model across the coming clock edge.
    exp_rv = 1'b0;
    case (ph)
      0: if (pk >= 0) begin
        g       = pk;
        c_addr  = req_addr[pk*AW +: AW];
        c_wdata = req_wdata[pk*DW +: DW];
        c_wmask = req_wmask[pk*MW +: MW];
        c_we    = req_we[pk];
        done_p[pk] = 1'b1;
        grants_q.push_back(pk);
        rdy_dly = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(3, 0));
        ph = 1;
      end
      1: if (mem_req_ready) begin
        int r;
        wcyc = 0;
        r = int'($urandom_range(20, 1));
        resp_at = (fix_resp >= 0) ? fix_resp : ((r > TO) ? 0 : r);
        ph = 2;
      end else begin
        rdy_dly--;
      end
      default: begin
        wcyc++;
        if (mem_resp_valid || wcyc == TO) begin
          exp_rv    = 1'b1;
          exp_port  = g;
          exp_rdata = mem_resp_valid ? mem_resp_rdata : '0;
          exp_err   = !mem_resp_valid;
          last      = g;
          n_done++;
          ph = 0;
        end
      end
    endcase
  endtask

  task automatic run_txns(input int k, input int bound);
    int start = n_done;
    int i = 0;
    while (n_done < start + k && i < bound) begin
      step();
      i++;
    end
    check_val("txn_count", n_done - start, k);
    step();
  endtask

  task automatic drain(input int bound);
    int i = 0;
    req_pct = 0;
    drop_en = 1'b0;
    while ((req_valid != '0 || ph != 0) && i < bound) begin
      step();
      i++;
    end
    check_val("drain_idle", (req_valid == '0 && ph == 0), 1);
    step();
  endtask

  task automatic model_reset();
    ph = 0;
    last = N - 1;
    exp_rv = 1'b0;
    done_p = '0;
    req_valid = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  // Assert reset between clock edges, check outputs at once, then release.
  task automatic async_reset(input string tag);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_all_zero(tag);
    model_reset();
    @(negedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic set_dir(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, input logic we);
    dir_en = 1'b1; dir_port = p; dir_addr = a; dir_wdata = d; dir_wmask = m; dir_we = we;
  endtask

  initial begin
    int i;
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_wmask = '0; req_we = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    #3 check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Stray completions while idle must be ignored.
    stray_pct = 100;
    repeat (5) step();
    stray_pct = 0;

    // Single read on port 1.
    fix_rdy = 2; fix_resp = 3; fix_rdata_en = 1'b1; fix_rdata = 32'hDEADBEEF;
    set_dir(1, 25'h0001000, 32'h0, 4'h0, 1'b0);
    run_txns(1, 50);
    fix_rdata_en = 1'b0;

    // Round-robin with every port requesting continuously, from reset.
    async_reset("rst_rr");
    grants_q.delete();
    req_pct = 100; fix_rdy = -1; fix_resp = 2;
    run_txns(6, 400);
    for (int k = 0; k < 6 && k < grants_q.size(); k++) begin
      check_val("rr_order", grants_q[k], k % N);
    end
    drain(200);

    // Masked write on port 2 held for several cycles before acceptance.
    fix_rdy = 4; fix_resp = 2;
    set_dir(2, 25'h1ABCDE0, 32'h12345678, 4'b0011, 1'b1);
    run_txns(1, 50);

    // Watchdog timeout, then a normal transaction.
    fix_rdy = 1; fix_resp = 0;
    set_dir(0, 25'h0000040, 32'h0, 4'h0, 1'b0);
    run_txns(1, 60);
    fix_resp = TO;
    set_dir(1, 25'h0000080, 32'h0, 4'h0, 1'b0);
    run_txns(1, 60);

    // Reset while awaiting a response, then all ports request.
    fix_resp = 0; req_pct = 100;
    i = 0;
    while (ph != 2 && i < 50) begin
      step();
      i++;
    end
    check_val("reach_wait", ph, 2);
    repeat (3) step();
    async_reset("rst_mid");
    grants_q.delete();
    fix_resp = 2;
    run_txns(1, 50);
    check_val("first_after_reset", (grants_q.size() > 0) ? grants_q[0] : -1, 0);
    drain(200);

    // Random traffic.
    req_pct = 30; drop_en = 1'b1; stray_pct = 10; fix_rdy = -1; fix_resp = -1;
    repeat (3000) step();
    stray_pct = 0;
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
